// File: rtl/div_issue_ctrl.sv
// Issue sequencer and result collector for the fixed-point divider: operand FIFO,
// start/wait/hold control and a watchdog that aborts a divider that never answers.
module div_issue_ctrl #(
    parameter int unsigned W       = 10,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    output logic         div_start,
    output logic         div_sclr,
    input  logic         div_busy,
    input  logic         div_valid,
    input  logic [W-1:0] div_q,
    input  logic         div_dvz,
    input  logic         div_ovf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_q,
    output logic         res_dvz,
    output logic         res_ovf,
    output logic         res_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    logic [W-1:0]  mem_a_q [DEPTH];
    logic [W-1:0]  mem_b_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          empty, full_d, push, pop, in_ready_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  div_a_q, div_a_d, div_b_q, div_b_d, res_q_q, res_q_d;
    logic          start_q, start_d, sclr_q, sclr_d;
    logic          res_valid_q, res_valid_d, res_dvz_q, res_dvz_d;
    logic          res_ovf_q, res_ovf_d, res_err_q, res_err_d;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = in_valid && in_ready_q;
    assign pop      = (state_q == StIdle) && !empty && !div_busy;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    // in_ready is registered, so it reflects fullness after this edge's push/pop.
    assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q[AW-1:0]] <= in_a;
            mem_b_q[wr_ptr_q[AW-1:0]] <= in_b;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        sclr_d      = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        res_valid_d = res_valid_q;
        res_q_d     = res_q_q;
        res_dvz_d   = res_dvz_q;
        res_ovf_d   = res_ovf_q;
        res_err_d   = res_err_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    div_a_d = mem_a_q[rd_ptr_q[AW-1:0]];
                    div_b_d = mem_b_q[rd_ptr_q[AW-1:0]];
                    start_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A result arriving on the last allowed cycle beats the watchdog.
                if (div_valid) begin
                    res_q_d     = div_q;
                    res_dvz_d   = div_dvz;
                    res_ovf_d   = div_ovf;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_q_d     = '0;
                    res_dvz_d   = 1'b0;
                    res_ovf_d   = 1'b0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    sclr_d      = 1'b1;
                    state_d     = StHold;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            sclr_q      <= 1'b1;
            div_a_q     <= '0;
            div_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_q_q     <= '0;
            res_dvz_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= !full_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            sclr_q      <= sclr_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            res_valid_q <= res_valid_d;
            res_q_q     <= res_q_d;
            res_dvz_q   <= res_dvz_d;
            res_ovf_q   <= res_ovf_d;
            res_err_q   <= res_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_start = start_q;
    assign div_sclr  = sclr_q;
    assign res_valid = res_valid_q;
    assign res_q     = res_q_q;
    assign res_dvz   = res_dvz_q;
    assign res_ovf   = res_ovf_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider stub, transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_div_issue_ctrl;
    localparam int W       = 10;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    localparam int PhIdle  = 0;
    localparam int PhIssue = 1;
    localparam int PhWait  = 2;
    localparam int PhHold  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [W-1:0] div_a, div_b;
    logic         div_start, div_sclr;
    logic         div_busy = 1'b0, div_valid = 1'b0;
    logic [W-1:0] div_q = '0;
    logic         div_dvz = 1'b0, div_ovf = 1'b0;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] res_q;
    logic         res_dvz, res_ovf, res_err;

    div_issue_ctrl #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_sclr(div_sclr),
        .div_busy(div_busy), .div_valid(div_valid), .div_q(div_q),
        .div_dvz(div_dvz), .div_ovf(div_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
        .res_dvz(res_dvz), .res_ovf(res_ovf), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Q6.4 divide: returns {ovf, dvz, q}.
    function automatic logic [11:0] ref_div(input logic [9:0] a, input logic [9:0] b);
        int unsigned quo;
        if (b == 10'd0) return {1'b0, 1'b1, 10'd0};
        quo = (int'(a) * 16) / int'(b);
        if (quo > 1023) return {1'b1, 1'b0, 10'h3ff};
        return {2'b00, quo[9:0]};
    endfunction

    // Shared stub / model controls
    bit hang_mode  = 0;
    bit force_busy = 0;
    bit noise_en   = 0;
    int fixed_lat  = 3;

    // Reference model state
    logic [19:0] exp_q [$];
    int          phase = PhIdle;
    int          cycles = 0;
    int          wait_n = 0;
    int          res_seen = 0;
    bit          exp_in_ready = 0;
    bit          sclr_flag = 0;
    bit          prev_start = 0;
    logic [9:0]  cur_a = '0, cur_b = '0;
    logic [9:0]  exp_rq = '0;
    logic        exp_dvz = 0, exp_ovf = 0, exp_err = 0;

    // Divider stub
    initial begin
        bit         sbusy = 0;
        int         scnt = 0;
        logic [9:0] sa = '0, sb = '0;
        forever begin
            @(negedge clk);
            div_valid = 1'b0;
            if (div_sclr) begin
                sbusy = 0;
                scnt  = 0;
            end else if (div_start) begin
                sbusy = 1;
                scnt  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
                sa    = div_a;
                sb    = div_b;
                if (noise_en && ($urandom_range(0, 1) == 1)) begin
                    div_valid = 1'b1;
                    div_q     = 10'($urandom);
                    div_dvz   = 1'($urandom);
                    div_ovf   = 1'($urandom);
                end
            end else if (sbusy && !hang_mode && scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    {div_ovf, div_dvz, div_q} = ref_div(sa, sb);
                    div_valid = 1'b1;
                    sbusy     = 0;
                end
            end
            div_busy = sbusy || force_busy;
        end
    end

    // Model: events sampled at the clock edge
    initial begin
        logic [11:0] r;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                phase     = PhIdle;
                cycles    = 0;
                sclr_flag = 0;
            end else begin
                cycles++;
                sclr_flag = 0;
                if (in_valid && exp_in_ready) exp_q.push_back({in_a, in_b});
                case (phase)
                    PhIssue: begin
                        phase  = PhWait;
                        wait_n = 0;
                    end
                    PhWait: begin
                        if (div_valid) begin
                            r = ref_div(cur_a, cur_b);
                            {exp_ovf, exp_dvz, exp_rq} = r;
                            exp_err = 0;
                            phase   = PhHold;
                        end else begin
                            wait_n++;
                            if (wait_n == TIMEOUT) begin
                                {exp_ovf, exp_dvz, exp_rq} = 12'd0;
                                exp_err   = 1;
                                sclr_flag = 1;
                                phase     = PhHold;
                            end
                        end
                    end
                    PhHold: begin
                        if (res_ready) begin
                            phase = PhIdle;
                            res_seen++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare process: DUT outputs against the model, away from the active edge
    initial begin
        logic [19:0] pair;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_res_valid", 32'(res_valid), 0);
                check("rst_in_ready", 32'(in_ready), 0);
                check("rst_sclr", 32'(div_sclr), 1);
                check("rst_start", 32'(div_start), 0);
                prev_start   = 0;
                exp_in_ready = 0;
            end else begin
                if (div_start) begin
                    check("start_one_cycle", 32'(prev_start), 0);
                    check("start_only_when_idle", 32'(phase), PhIdle);
                    if (exp_q.size() == 0) begin
                        check("start_with_empty_fifo", 32'(div_start), 0);
                    end else begin
                        pair  = exp_q.pop_front();
                        cur_a = pair[19:10];
                        cur_b = pair[9:0];
                        check("issue_a_order", 32'(div_a), 32'(cur_a));
                        check("issue_b_order", 32'(div_b), 32'(cur_b));
                    end
                    phase = PhIssue;
                end else if (phase != PhIdle) begin
                    check("div_a_stable", 32'(div_a), 32'(cur_a));
                    check("div_b_stable", 32'(div_b), 32'(cur_b));
                end
                prev_start   = div_start;
                exp_in_ready = (cycles > 0) && (exp_q.size() < DEPTH);
                check("in_ready", 32'(in_ready), 32'(exp_in_ready));
                check("sclr", 32'(div_sclr), 32'(sclr_flag));
                if (phase == PhHold) begin
                    check("res_valid_hold", 32'(res_valid), 1);
                    check("res_q", 32'(res_q), 32'(exp_rq));
                    check("res_dvz", 32'(res_dvz), 32'(exp_dvz));
                    check("res_ovf", 32'(res_ovf), 32'(exp_ovf));
                    check("res_err", 32'(res_err), 32'(exp_err));
                end else begin
                    check("res_valid_idle", 32'(res_valid), 0);
                end
            end
        end
    end

    task automatic push(input logic [9:0] a, input logic [9:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int bound);
        int n = 0;
        while (!res_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("res_arrives", 32'(res_valid), 1);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_released", 32'(res_valid), 0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        res_ready = 1'b1;
        while ((exp_q.size() != 0 || phase != PhIdle) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", 32'(exp_q.size() == 0 && phase == PhIdle), 1);
        res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_sclr", 32'(div_sclr), 0);

        // 20.0 / 4.0 with start latency and literal result
        push(10'b0101000000, 10'b0001000000);
        check("lat_edge_n1_start", 32'(div_start), 0);
        @(negedge clk);
        check("lat_edge_n2_start", 32'(div_start), 1);
        check("lat_div_a", 32'(div_a), 32'(10'b0101000000));
        @(negedge clk);
        check("start_dropped", 32'(div_start), 0);
        wait_res(40);
        check("q_20_div_4", 32'(res_q), 32'(10'b0001010000));
        check("q_20_div_4_dvz", 32'(res_dvz), 0);
        check("q_20_div_4_err", 32'(res_err), 0);
        release_res();

        // Divide by zero, then a normal op behind it
        push(10'b0101000000, 10'b0000000000);
        push(10'b0101000000, 10'b0001000000);
        wait_res(40);
        check("dvz_flag", 32'(res_dvz), 1);
        check("dvz_err", 32'(res_err), 0);
        release_res();
        wait_res(40);
        check("after_dvz_q", 32'(res_q), 32'(10'b0001010000));
        check("after_dvz_flag", 32'(res_dvz), 0);
        release_res();

        // FIFO full while the divider is held busy
        force_busy = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) push(10'(64 * (i + 1)), 10'd64);
        check("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_a     = 10'd320;
        in_b     = 10'd64;
        repeat (3) @(negedge clk);
        check("full_stalled", 32'(in_ready), 0);
        check("full_no_start", 32'(div_start), 0);
        base       = res_seen;
        force_busy = 0;
        res_ready  = 1'b1;
        push(10'd320, 10'd64);
        drain(400);
        check("full_result_count", 32'(res_seen - base), 5);

        // Watchdog on a divider that never answers
        hang_mode = 1;
        push(10'd100, 10'd10);
        n = 0;
        while (!div_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_issue", 32'(div_start), 1);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), TIMEOUT + 1);
        check("timeout_err", 32'(res_err), 1);
        check("timeout_q", 32'(res_q), 0);
        check("timeout_sclr_on", 32'(div_sclr), 1);
        @(negedge clk);
        check("timeout_sclr_off", 32'(div_sclr), 0);
        hang_mode = 0;
        release_res();

        // Backpressure: result held, no new issue
        push(10'd160, 10'd32);
        push(10'd64, 10'd64);
        wait_res(40);
        for (int i = 0; i < 10; i++) begin
            check("bp_res_q", 32'(res_q), 80);
            check("bp_no_start", 32'(div_start), 0);
            @(negedge clk);
        end
        release_res();
        n = 0;
        while (!div_start && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_issue", 32'(div_start), 1);
        wait_res(40);
        check("bp_second_q", 32'(res_q), 16);
        release_res();

        // Randomized traffic
        noise_en  = 1;
        fixed_lat = 0;
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 10'($urandom);
            in_b      = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        noise_en = 0;
        drain(2000);
        fixed_lat = 3;

        // Reset in the middle of a wait with another op queued
        hang_mode = 1;
        push(10'd200, 10'd20);
        push(10'd300, 10'd30);
        n = 0;
        while (!div_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 0);
        check("async_rst_sclr", 32'(div_sclr), 1);
        check("async_rst_res_valid", 32'(res_valid), 0);
        hang_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_sclr_drop", 32'(div_sclr), 0);
        check("rel_in_ready", 32'(in_ready), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (div_start || res_valid) n++;
        end
        check("rel_no_stale_activity", 32'(n), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Upstream sequencer and result collector for the team's 10-bit fixed-point divider (Q6.4, e.g. 20.0 = 0101000000). It accepts operand pairs through a valid/ready handshake and buffers them in a small FIFO. It issues each pair to the divider with a one-cycle start pulse and waits for the divider's valid. It then returns the quotient and status flags through a valid/ready handshake, and a timeout watchdog recovers from a hung divider.

Parameters:
W, 10, operand/quotient width
DEPTH, 4, operand FIFO depth (power of 2, >=2)
TIMEOUT, 32, max cycles waited for div_valid after issue before abort

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair available
in_ready  output  1  FIFO can accept (not full)
in_a  input  W  dividend
in_b  input  W  divisor
div_a  output  W  dividend to divider, held stable from issue until result
div_b  output  W  divisor to divider, held stable from issue until result
div_start  output  1  one-cycle issue pulse to divider
div_sclr  output  1  synchronous clear to divider
div_busy  input  1  divider busy
div_valid  input  1  divider result valid
div_q  input  W  divider quotient
div_dvz  input  1  divide-by-zero flag
div_ovf  input  1  overflow flag
res_valid  output  1  result held for consumer
res_ready  input  1  consumer accepts result
res_q  output  W  captured quotient
res_dvz  output  1  captured dvz
res_ovf  output  1  captured ovf
res_err  output  1  result produced by timeout abort

Behaviour:
- Reset (async, any time, including mid-operation):
  - FIFO emptied; FSM to IDLE.
  - Outputs reset to: div_a/div_b=0, div_start=0, res_valid=0, res_q=0, res_dvz/res_ovf/res_err=0, in_ready=0.
  - div_sclr=1 during reset and drops at the first clk edge after rst deasserts, clearing the divider.
  - In-flight operation and queued pairs are discarded.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.
  - in_ready = !full (registered state). Push on in_valid && in_ready.
  - When full, a same-cycle pop does not enable a push.
  - Push and pop in the same cycle while non-full and non-empty: count unchanged.
  - Pointers wrap modulo DEPTH. Strict FIFO order.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO not empty and div_busy=0 -> ISSUE, popping the head into div_a/div_b at the same edge.
  - ISSUE (1 cycle): div_start=1; timeout counter cleared -> WAIT. div_valid sampled in ISSUE is ignored.
  - WAIT: div_start=0; counter increments each cycle.
    - div_valid=1: capture div_q/div_dvz/div_ovf into res_*, res_err=0 -> HOLD.
    - Counter reaches TIMEOUT with no valid: res_q=0, res_dvz=0, res_ovf=0, res_err=1; div_sclr=1 for exactly one cycle -> HOLD.
    - If div_valid and the timeout coincide, div_valid wins.
  - HOLD: res_valid=1, all res_* stable. On res_ready: res_valid drops next cycle -> IDLE. No new issue while in HOLD.
- Latency: pair pushed at edge N into an empty FIFO with the divider idle gives div_start high in cycle N+2. res_valid rises one cycle after the div_valid cycle. Back-to-back throughput is one result per (divider latency + 3) cycles with res_ready held high.
- res_dvz and res_ovf are pass-through captures; this block does not check divisor zero itself.
- Counter width: clog2(TIMEOUT+1).

Test Plan:
- Single op with the team divider: push a=0101000000 (20.0), b=0001000000 (4.0) -> div_start is a one-cycle pulse two cycles after the push; res_valid=1 with res_q=0001010000 (5.0), res_dvz=0, res_ovf=0, res_err=0; released by res_ready.
- Divide by zero: push a=0101000000, b=0000000000 -> res_valid=1, res_dvz=1, res_err=0; next queued op then issues normally.
- FIFO full/ordering: stub holds div_busy=1 while 5 pairs are offered -> 4 accepted, in_ready=0 with 5th stalled. Release busy -> 5 results in push order; in_ready returns high after the first pop.
- Timeout: stub never asserts div_valid, TIMEOUT=16 -> after 16 WAIT cycles div_sclr pulses exactly one cycle; res_valid=1, res_err=1, res_q=0.
- Backpressure: res_ready=0 for 10 cycles in HOLD -> res_* stable, no further div_start; res_ready=1 -> next issue follows.
- Reset mid-WAIT: assert rst asynchronously -> res_valid=0 and in_ready=0 immediately, div_sclr=1. After release: div_sclr drops on the next edge and the FIFO is empty (no stale result or issue).
